// File: rtl/spi_master_tx_if.sv
// Word stream between the buffer RAM read port and the SPI master shift engine.
interface spi_master_tx_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic [DATA_W-1:0] TX_DAT;
  logic              TX_VALID;
  logic              TX_READY;
  logic [DATA_W-1:0] RX_DAT;
  logic              RX_VALID;

  // Upstream side: offers words, receives captured words.
  modport master (
    output TX_DAT,
    output TX_VALID,
    input  TX_READY,
    input  RX_DAT,
    input  RX_VALID
  );

  // Shift-engine side.
  modport slave (
    input  TX_DAT,
    input  TX_VALID,
    output TX_READY,
    output RX_DAT,
    output RX_VALID
  );

endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: serialises one word MSB-first on MOSI while capturing MISO,
// with SCLK generated internally from CLK (CLK_DIV cycles per half-period).
module spi_master_tx #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic           CLK,
  input  logic           RST,
  spi_master_tx_if.slave bus,
  output logic           BUSY,
  output logic           SCLK,
  output logic           MOSI,
  input  logic           MISO,
  output logic           SS_N
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL
  } state_e;

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [DATA_W-1:0] tx_sr_q,    tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q,    rx_sr_d;
  logic [DATA_W-1:0] rx_dat_q,   rx_dat_d;
  logic              rx_valid_q, rx_valid_d;
  logic              sclk_q,     sclk_d;
  logic              ss_n_q,     ss_n_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q,     busy_d;
  logic              tick;

  // Next-state, divider, shift and output decode.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_dat_d   = rx_dat_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    tick       = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (bus.TX_VALID && tx_ready_q) begin
          state_d   = LEAD;
          tx_sr_d   = bus.TX_DAT;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          ss_n_d    = 1'b0;
        end
      end
      LEAD, LOW: begin
        // Rising SCLK edge: capture MISO into the LSB.
        if (tick) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
          rx_sr_d = (rx_sr_q << 1) | DATA_W'(MISO);
        end
      end
      HIGH: begin
        // Falling SCLK edge: present the next bit unless the word is done.
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = TRAIL;
          end else begin
            state_d   = LOW;
            tx_sr_d   = tx_sr_q << 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          state_d    = IDLE;
          ss_n_d     = 1'b1;
          tx_sr_d    = '0;
          rx_dat_d   = rx_sr_q;
          rx_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Divider restarts on every state change and is held clear in IDLE.
    cnt_d      = ((state_q == IDLE) || tick) ? '0 : cnt_q + CNT_W'(1);
    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_dat_q   <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_dat_q   <= rx_dat_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  // MOSI is the MSB of the transmit shift register, which is cleared when idle.
  assign MOSI         = tx_sr_q[DATA_W-1];
  assign SCLK         = sclk_q;
  assign SS_N         = ss_n_q;
  assign BUSY         = busy_q;
  assign bus.TX_READY = tx_ready_q;
  assign bus.RX_DAT   = rx_dat_q;
  assign bus.RX_VALID = rx_valid_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: default instance plus a CLK_DIV=1 instance.
module tb_spi_master_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_tx_if #(.DATA_W(16)) bus0 ();
  spi_master_tx_if #(.DATA_W(16)) bus1 ();

  logic busy0, sclk0, mosi0, ss_n0;
  logic miso0 = 1'b0;
  logic busy1, sclk1, mosi1, ss_n1;

  spi_master_tx #(.DATA_W(16), .CLK_DIV(4)) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus0),
    .BUSY(busy0),
    .SCLK(sclk0),
    .MOSI(mosi0),
    .MISO(miso0),
    .SS_N(ss_n0)
  );

  spi_master_tx #(.DATA_W(16), .CLK_DIV(1)) u_dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (bus1),
    .BUSY(busy1),
    .SCLK(sclk1),
    .MOSI(mosi1),
    .MISO(1'b0),
    .SS_N(ss_n1)
  );

  // Slave model: MSB at SS_N fall, next bit after each SCLK fall.
  logic [15:0] slave_word = 16'h0000;
  logic [15:0] sl_sr = 16'h0000;
  logic        sl_pss = 1'b1;
  logic        sl_psclk = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!ss_n0 && sl_pss) sl_sr = slave_word;
    else if (!ss_n0 && !sclk0 && sl_psclk) sl_sr = sl_sr << 1;
    miso0 = sl_sr[15];
    sl_pss = ss_n0;
    sl_psclk = sclk0;
  end

  // Monitor for the default instance.
  int          ss_low0 = 0, rise0 = 0, mosi_bad0 = 0, rxv0 = 0;
  int          last_rxc0 = 0, prev_rxc0 = 0;
  logic [15:0] mosi_sr0 = 16'h0, last_mw0 = 16'h0, prev_mw0 = 16'h0;
  logic        psclk0 = 1'b0, pmosi0 = 1'b0;
  always @(negedge clk) begin
    if (!ss_n0) ss_low0++;
    if (sclk0 && !psclk0) begin
      rise0++;
      mosi_sr0 = {mosi_sr0[14:0], mosi0};
    end
    if (sclk0 && (mosi0 !== pmosi0)) mosi_bad0++;
    if (bus0.RX_VALID) begin
      rxv0++;
      prev_rxc0 = last_rxc0;
      last_rxc0 = cyc;
      prev_mw0  = last_mw0;
      last_mw0  = mosi_sr0;
    end
    psclk0 = sclk0;
    pmosi0 = mosi0;
  end

  // Monitor for the CLK_DIV=1 instance.
  int          ss_low1 = 0, rise1 = 0, per_bad1 = 0, rxv1 = 0, lrc1 = 0;
  logic [15:0] mosi_sr1 = 16'h0;
  logic        psclk1 = 1'b0, have1 = 1'b0;
  always @(negedge clk) begin
    if (!ss_n1) ss_low1++;
    if (sclk1 && !psclk1) begin
      if (have1 && ((cyc - lrc1) != 2)) per_bad1++;
      have1 = 1'b1;
      lrc1 = cyc;
      rise1++;
      mosi_sr1 = {mosi_sr1[14:0], mosi1};
    end
    if (ss_n1) have1 = 1'b0;
    if (bus1.RX_VALID) rxv1++;
    psclk1 = sclk1;
  end

  task automatic send0(input logic [15:0] d);
    int n = 0;
    bus0.TX_DAT = d;
    bus0.TX_VALID = 1'b1;
    while (bus0.TX_READY !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus0.TX_VALID = 1'b0;
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL send_timeout: waited %0d cycles, required < 400", n);
    end
  endtask

  task automatic wait_rx0(input int limit);
    int n = 0;
    while (bus0.RX_VALID !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL rx_timeout: waited %0d cycles, required < %0d", n, limit);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus0.TX_VALID = 1'b1;
    bus0.TX_DAT = 16'hA5C3;
    bus1.TX_VALID = 1'b1;
    bus1.TX_DAT = 16'hFFFF;
    repeat (2) @(negedge clk);
    checks++; if (ss_n0 !== 1'b1) begin errors++; $display("FAIL reset_ss_n: got %b required 1", ss_n0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b required 0", sclk0); end
    checks++; if (mosi0 !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b required 0", mosi0); end
    checks++; if (bus0.TX_READY !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b required 1", bus0.TX_READY); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy0); end
    checks++; if (bus0.RX_VALID !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b required 0", bus0.RX_VALID); end
    checks++; if (bus0.RX_DAT !== 16'h0000) begin errors++; $display("FAIL reset_rx_dat: got %h required 0000", bus0.RX_DAT); end
    checks++; if (ss_n1 !== 1'b1) begin errors++; $display("FAIL reset_ss_n_div1: got %b required 1", ss_n1); end
    #1;
    bus0.TX_VALID = 1'b0;
    bus1.TX_VALID = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b required 0", busy0); end
  endtask

  task automatic test_single;
    int b_ss, b_rxv, b_rise;
    @(negedge clk); #1;
    b_ss = ss_low0; b_rxv = rxv0; b_rise = rise0;
    slave_word = 16'h3C5A;
    send0(16'hA5C3);
    wait_rx0(300);
    checks++; if (bus0.RX_DAT !== 16'h3C5A) begin errors++; $display("FAIL single_rx_dat: got %h required 3c5a", bus0.RX_DAT); end
    checks++; if (bus0.TX_READY !== 1'b1) begin errors++; $display("FAIL single_ready_at_rxv: got %b required 1", bus0.TX_READY); end
    checks++; if (ss_n0 !== 1'b1) begin errors++; $display("FAIL single_ss_n_at_rxv: got %b required 1", ss_n0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy_at_rxv: got %b required 0", busy0); end
    repeat (3) @(negedge clk); #1;
    checks++; if (ss_low0 - b_ss != 132) begin errors++; $display("FAIL single_ss_low_len: got %0d required 132", ss_low0 - b_ss); end
    checks++; if (rise0 - b_rise != 16) begin errors++; $display("FAIL single_sclk_rises: got %0d required 16", rise0 - b_rise); end
    checks++; if (rxv0 - b_rxv != 1) begin errors++; $display("FAIL single_rxv_count: got %0d required 1", rxv0 - b_rxv); end
    checks++; if (last_mw0 !== 16'hA5C3) begin errors++; $display("FAIL single_mosi_word: got %h required a5c3", last_mw0); end
    checks++; if (mosi_bad0 != 0) begin errors++; $display("FAIL single_mosi_stable: got %0d changes required 0", mosi_bad0); end
  endtask

  task automatic test_back_to_back;
    int b_ss, b_rxv, n;
    @(negedge clk); #1;
    b_ss = ss_low0; b_rxv = rxv0;
    slave_word = 16'hC001;
    bus0.TX_DAT = 16'h0001;
    bus0.TX_VALID = 1'b1;
    @(negedge clk);
    bus0.TX_DAT = 16'h8000;
    checks++; if (bus0.TX_READY !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy: got %b required 0", bus0.TX_READY); end
    n = 0;
    while (bus0.TX_READY !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 300) begin errors++; $display("FAIL b2b_ready_timeout: waited %0d required < 300", n); end
    checks++; if (bus0.RX_VALID !== 1'b1) begin errors++; $display("FAIL b2b_accept_in_rxv: got %b required 1", bus0.RX_VALID); end
    checks++; if (ss_n0 !== 1'b1) begin errors++; $display("FAIL b2b_gap_ss_n: got %b required 1", ss_n0); end
    checks++; if (bus0.RX_DAT !== 16'hC001) begin errors++; $display("FAIL b2b_rx_dat1: got %h required c001", bus0.RX_DAT); end
    @(negedge clk);
    bus0.TX_VALID = 1'b0;
    checks++; if (ss_n0 !== 1'b0) begin errors++; $display("FAIL b2b_ss_n_refall: got %b required 0", ss_n0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_busy2: got %b required 1", busy0); end
    wait_rx0(300);
    checks++; if (bus0.RX_DAT !== 16'hC001) begin errors++; $display("FAIL b2b_rx_dat2: got %h required c001", bus0.RX_DAT); end
    repeat (3) @(negedge clk); #1;
    checks++; if (last_rxc0 - prev_rxc0 != 133) begin errors++; $display("FAIL b2b_rxv_spacing: got %0d required 133", last_rxc0 - prev_rxc0); end
    checks++; if (prev_mw0 !== 16'h0001) begin errors++; $display("FAIL b2b_mosi_word1: got %h required 0001", prev_mw0); end
    checks++; if (last_mw0 !== 16'h8000) begin errors++; $display("FAIL b2b_mosi_word2: got %h required 8000", last_mw0); end
    checks++; if (ss_low0 - b_ss != 264) begin errors++; $display("FAIL b2b_ss_low_total: got %0d required 264", ss_low0 - b_ss); end
    checks++; if (rxv0 - b_rxv != 2) begin errors++; $display("FAIL b2b_rxv_count: got %0d required 2", rxv0 - b_rxv); end
  endtask

  task automatic test_busy_reject;
    int b_ss, b_rxv;
    @(negedge clk); #1;
    b_ss = ss_low0; b_rxv = rxv0;
    slave_word = 16'h0000;
    send0(16'h1234);
    repeat (18) @(negedge clk);
    bus0.TX_DAT = 16'hFFFF;
    bus0.TX_VALID = 1'b1;
    checks++; if (bus0.TX_READY !== 1'b0) begin errors++; $display("FAIL reject_ready: got %b required 0", bus0.TX_READY); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL reject_busy: got %b required 1", busy0); end
    @(negedge clk);
    bus0.TX_VALID = 1'b0;
    wait_rx0(300);
    checks++; if (bus0.RX_DAT !== 16'h0000) begin errors++; $display("FAIL reject_rx_dat: got %h required 0000", bus0.RX_DAT); end
    repeat (150) @(negedge clk); #1;
    checks++; if (rxv0 - b_rxv != 1) begin errors++; $display("FAIL reject_rxv_count: got %0d required 1", rxv0 - b_rxv); end
    checks++; if (ss_low0 - b_ss != 132) begin errors++; $display("FAIL reject_ss_low_len: got %0d required 132", ss_low0 - b_ss); end
    checks++; if (last_mw0 !== 16'h1234) begin errors++; $display("FAIL reject_mosi_word: got %h required 1234", last_mw0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reject_busy_after: got %b required 0", busy0); end
  endtask

  task automatic test_reset_mid;
    int b_rxv, n, r;
    logic p;
    @(negedge clk); #1;
    b_rxv = rxv0;
    slave_word = 16'hFFFF;
    send0(16'hF0F0);
    n = 0; r = 0; p = sclk0;
    while (r < 8 && n < 200) begin
      @(negedge clk);
      if (sclk0 && !p) r++;
      p = sclk0;
      n++;
    end
    checks++; if (r != 8) begin errors++; $display("FAIL midrst_rise_timeout: got %0d rises required 8", r); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ss_n0 !== 1'b1) begin errors++; $display("FAIL midrst_ss_n: got %b required 1", ss_n0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("FAIL midrst_sclk: got %b required 0", sclk0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy0); end
    checks++; if (bus0.RX_VALID !== 1'b0) begin errors++; $display("FAIL midrst_rx_valid: got %b required 0", bus0.RX_VALID); end
    rst = 1'b1;
    repeat (150) @(negedge clk); #1;
    checks++; if (rxv0 - b_rxv != 0) begin errors++; $display("FAIL midrst_no_rxv: got %0d required 0", rxv0 - b_rxv); end
    checks++; if (bus0.RX_DAT !== 16'h0000) begin errors++; $display("FAIL midrst_rx_dat: got %h required 0000", bus0.RX_DAT); end
    slave_word = 16'h5A5A;
    send0(16'h00FF);
    wait_rx0(300);
    checks++; if (bus0.RX_DAT !== 16'h5A5A) begin errors++; $display("FAIL midrst_next_rx_dat: got %h required 5a5a", bus0.RX_DAT); end
    repeat (3) @(negedge clk); #1;
    checks++; if (last_mw0 !== 16'h00FF) begin errors++; $display("FAIL midrst_next_mosi: got %h required 00ff", last_mw0); end
  endtask

  task automatic test_clk_div1;
    int b_ss, b_rise, b_per, b_rxv, n;
    @(negedge clk); #1;
    b_ss = ss_low1; b_rise = rise1; b_per = per_bad1; b_rxv = rxv1;
    checks++; if (bus1.TX_READY !== 1'b1) begin errors++; $display("FAIL div1_ready: got %b required 1", bus1.TX_READY); end
    bus1.TX_DAT = 16'hFFFF;
    bus1.TX_VALID = 1'b1;
    @(negedge clk);
    bus1.TX_VALID = 1'b0;
    n = 0;
    while (bus1.RX_VALID !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 100) begin errors++; $display("FAIL div1_rx_timeout: waited %0d required < 100", n); end
    checks++; if (bus1.RX_DAT !== 16'h0000) begin errors++; $display("FAIL div1_rx_dat: got %h required 0000", bus1.RX_DAT); end
    repeat (3) @(negedge clk); #1;
    checks++; if (ss_low1 - b_ss != 33) begin errors++; $display("FAIL div1_ss_low_len: got %0d required 33", ss_low1 - b_ss); end
    checks++; if (rise1 - b_rise != 16) begin errors++; $display("FAIL div1_sclk_rises: got %0d required 16", rise1 - b_rise); end
    checks++; if (per_bad1 - b_per != 0) begin errors++; $display("FAIL div1_sclk_period: got %0d bad periods required 0", per_bad1 - b_per); end
    checks++; if (mosi_sr1 !== 16'hFFFF) begin errors++; $display("FAIL div1_mosi_word: got %h required ffff", mosi_sr1); end
    checks++; if (rxv1 - b_rxv != 1) begin errors++; $display("FAIL div1_rxv_count: got %0d required 1", rxv1 - b_rxv); end
  endtask

  initial begin
    bus0.TX_VALID = 1'b0;
    bus0.TX_DAT = 16'h0000;
    bus1.TX_VALID = 1'b0;
    bus1.TX_DAT = 16'h0000;
    test_reset;
    test_single;
    test_back_to_back;
    test_busy_reject;
    test_reset_mid;
    test_clk_div1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if the run ever wedges.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units");
    $fatal(1);
  end

endmodule
